// File: rtl/rounder_arbiter_pkg.sv
// Shared defaults and rounding-mode constants for the rounder arbiter slice.
package rounder_arbiter_pkg;

  // Default field widths for the single-precision use case.
  localparam int DEFAULT_EXPONENT_WIDTH = 8;
  localparam int DEFAULT_MANTISSA_WIDTH = 23;
  localparam int DEFAULT_ROUNDING_BITS  = 3;
  localparam int DEFAULT_NUM_REQUESTERS = 2;

  // Values accepted by the ROUND_TO_NEAREST parameter.
  localparam int ROUND_TO_NEAREST = 1;
  localparam int ROUND_TO_ZERO    = 0;

  typedef enum logic {
    RM_TRUNCATE     = 1'b0,
    RM_NEAREST_EVEN = 1'b1
  } round_mode_e;

  function automatic round_mode_e round_mode_from_param(input int rtn);
    return (rtn != ROUND_TO_ZERO) ? RM_NEAREST_EVEN : RM_TRUNCATE;
  endfunction

endpackage

// File: rtl/rounder_arbiter_rounder.sv
// Rounds a {exponent, mantissa, rounding_bits} value; flags overflow to infinity.
module result_rounder
  import rounder_arbiter_pkg::*;
#(
  parameter int EXPONENT_WIDTH   = DEFAULT_EXPONENT_WIDTH,
  parameter int MANTISSA_WIDTH   = DEFAULT_MANTISSA_WIDTH,
  parameter int ROUNDING_BITS    = DEFAULT_ROUNDING_BITS,
  parameter int ROUND_TO_NEAREST = 1
) (
  input  logic [EXPONENT_WIDTH-1:0] exponent_i,
  input  logic [MANTISSA_WIDTH-1:0] mantissa_i,
  input  logic [ROUNDING_BITS-1:0]  rounding_bits_i,
  output logic [EXPONENT_WIDTH-1:0] exponent_o,
  output logic [MANTISSA_WIDTH-1:0] mantissa_o,
  output logic                      overflow_o
);

  localparam round_mode_e MODE = round_mode_from_param(ROUND_TO_NEAREST);
  localparam logic [ROUNDING_BITS-1:0] HALF = {1'b1, {(ROUNDING_BITS-1){1'b0}}};

  logic                      round_up;
  logic                      carry;
  logic [MANTISSA_WIDTH-1:0] mant_sum;

  // Nearest-even increment, carry into the exponent, saturate at all-ones.
  always_comb begin
    round_up = (MODE == RM_NEAREST_EVEN) &&
               ((rounding_bits_i > HALF) || ((rounding_bits_i == HALF) && mantissa_i[0]));
    {carry, mant_sum} = {1'b0, mantissa_i} + {{MANTISSA_WIDTH{1'b0}}, round_up};
    exponent_o = exponent_i;
    mantissa_o = mant_sum;
    overflow_o = 1'b0;
    if (carry) begin
      // Mantissa wrapped to zero; an already-saturated exponent stays put.
      exponent_o = (exponent_i == '1) ? exponent_i : exponent_i + EXPONENT_WIDTH'(1);
      mantissa_o = '0;
      overflow_o = (exponent_o == '1);
    end
  end

endmodule

// File: rtl/rounder_arbiter_rr.sv
// Round-robin grant logic: first requester at or after the pointer, wrapping.
module round_robin_arbiter
  import rounder_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = DEFAULT_NUM_REQUESTERS,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req_i,
  input  logic [ID_WIDTH-1:0]       ptr_i,
  input  logic                      en_i,
  output logic [NUM_REQUESTERS-1:0] grant_o,
  output logic [ID_WIDTH-1:0]       idx_o
);

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    int  cand;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQUESTERS;
      if (!found && en_i && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = ID_WIDTH'(cand);
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rounder_arbiter.sv
// Shares one result_rounder among several producers with round-robin arbitration
// and a single registered output stage.
module rounder_arbiter
  import rounder_arbiter_pkg::*;
#(
  parameter int EXPONENT_WIDTH   = DEFAULT_EXPONENT_WIDTH,
  parameter int MANTISSA_WIDTH   = DEFAULT_MANTISSA_WIDTH,
  parameter int ROUNDING_BITS    = DEFAULT_ROUNDING_BITS,
  parameter int ROUND_TO_NEAREST = 1,
  parameter int NUM_REQUESTERS   = DEFAULT_NUM_REQUESTERS
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQUESTERS-1:0]              req_valid,
  output logic [NUM_REQUESTERS-1:0]              req_ready,
  input  logic [NUM_REQUESTERS-1:0]              req_sign,
  input  logic [NUM_REQUESTERS*EXPONENT_WIDTH-1:0] req_exponent,
  input  logic [NUM_REQUESTERS*MANTISSA_WIDTH-1:0] req_mantissa,
  input  logic [NUM_REQUESTERS*ROUNDING_BITS-1:0]  req_rounding_bits,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_sign,
  output logic [EXPONENT_WIDTH-1:0]              out_exponent,
  output logic [MANTISSA_WIDTH-1:0]              out_mantissa,
  output logic                                   out_overflow,
  output logic [$clog2(NUM_REQUESTERS)-1:0]      out_source_id
);

  localparam int ID_WIDTH = $clog2(NUM_REQUESTERS);

  logic [ID_WIDTH-1:0]       ptr_q, ptr_d;
  logic                      valid_q, valid_d;
  logic                      sign_q, sign_d;
  logic [EXPONENT_WIDTH-1:0] exp_q, exp_d;
  logic [MANTISSA_WIDTH-1:0] mant_q, mant_d;
  logic                      ovf_q, ovf_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;

  logic                      slot_free;
  logic [NUM_REQUESTERS-1:0] grant;
  logic [ID_WIDTH-1:0]       grant_idx;
  logic                      transfer;

  logic                      sel_sign;
  logic [EXPONENT_WIDTH-1:0] sel_exp;
  logic [MANTISSA_WIDTH-1:0] sel_mant;
  logic [ROUNDING_BITS-1:0]  sel_rbits;
  logic [EXPONENT_WIDTH-1:0] rnd_exp;
  logic [MANTISSA_WIDTH-1:0] rnd_mant;
  logic                      rnd_ovf;

  // The output register can accept new data when empty or draining this cycle.
  assign slot_free = !valid_q || out_ready;

  round_robin_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS),
    .ID_WIDTH      (ID_WIDTH)
  ) u_rr (
    .req_i  (req_valid),
    .ptr_i  (ptr_q),
    .en_i   (slot_free && !rst),
    .grant_o(grant),
    .idx_o  (grant_idx)
  );

  assign req_ready = grant;
  assign transfer  = |(req_valid & grant);

  // N:1 operand mux steered by the encoded grant index.
  always_comb begin
    sel_sign  = 1'b0;
    sel_exp   = '0;
    sel_mant  = '0;
    sel_rbits = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (grant_idx == ID_WIDTH'(k)) begin
        sel_sign  = req_sign[k];
        sel_exp   = req_exponent[k*EXPONENT_WIDTH +: EXPONENT_WIDTH];
        sel_mant  = req_mantissa[k*MANTISSA_WIDTH +: MANTISSA_WIDTH];
        sel_rbits = req_rounding_bits[k*ROUNDING_BITS +: ROUNDING_BITS];
      end
    end
  end

  result_rounder #(
    .EXPONENT_WIDTH  (EXPONENT_WIDTH),
    .MANTISSA_WIDTH  (MANTISSA_WIDTH),
    .ROUNDING_BITS   (ROUNDING_BITS),
    .ROUND_TO_NEAREST(ROUND_TO_NEAREST)
  ) u_rounder (
    .exponent_i     (sel_exp),
    .mantissa_i     (sel_mant),
    .rounding_bits_i(sel_rbits),
    .exponent_o     (rnd_exp),
    .mantissa_o     (rnd_mant),
    .overflow_o     (rnd_ovf)
  );

  // Next state: load on transfer, clear valid on an idle drain, hold under backpressure.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    ovf_d   = ovf_q;
    id_d    = id_q;
    if (slot_free) begin
      valid_d = transfer;
    end
    if (transfer) begin
      sign_d = sel_sign;
      exp_d  = rnd_exp;
      mant_d = rnd_mant;
      ovf_d  = rnd_ovf;
      id_d   = grant_idx;
      ptr_d  = (int'(grant_idx) == NUM_REQUESTERS - 1) ? '0 : grant_idx + ID_WIDTH'(1);
    end
  end

  // Output register and round-robin pointer; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      ovf_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_sign      = sign_q;
  assign out_exponent  = exp_q;
  assign out_mantissa  = mant_q;
  assign out_overflow  = ovf_q;
  assign out_source_id = id_q;

endmodule
